// File: rtl/aes_dec_loader.sv
// aes_dec_loader: collects a 16-byte key and 16-byte ciphertext from a byte stream for the AES-128 decrypt core.
// Define AES_LOADER_KEY_REUSE_EN to add a per-frame header byte whose bit0=0 reuses the held key.
module aes_dec_loader #(
    parameter int LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] key_out,
    output logic [127:0] data_out,
    output logic         start,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {HDR, KEY, DATA, WAIT} state_t;
`ifdef AES_LOADER_KEY_REUSE_EN
    localparam state_t FIRST = HDR;
    logic loaded_q, loaded_d;
`else
    localparam state_t FIRST = KEY;
`endif
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wait_q, wait_d;
    logic [127:0] key_sh_q, key_sh_d, data_sh_q, data_sh_d;
    logic [127:0] key_q, key_d, data_q, data_d;
    logic ready_q, ready_d, start_q, start_d, busy_q, busy_d, done_q, done_d;
    logic xfer;

    always_comb begin
        xfer      = in_valid && ready_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        key_sh_d  = key_sh_q;
        data_sh_d = data_sh_q;
        key_d     = key_q;
        data_d    = data_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
        loaded_d  = loaded_q;
`endif
        case (state_q)
`ifdef AES_LOADER_KEY_REUSE_EN
            HDR: if (xfer) state_d = (in_data[0] || !loaded_q) ? KEY : DATA;
`endif
            KEY: if (xfer) begin
                cnt_d    = cnt_q + 4'd1;
                key_sh_d = {key_sh_q[119:0], in_data};
                if (cnt_q == 4'd15) begin
                    key_d   = key_sh_d;
                    state_d = DATA;
`ifdef AES_LOADER_KEY_REUSE_EN
                    loaded_d = 1'b1;
`endif
                end
            end
            DATA: if (xfer) begin
                cnt_d     = cnt_q + 4'd1;
                data_sh_d = {data_sh_q[119:0], in_data};
                if (cnt_q == 4'd15) begin
                    data_d  = data_sh_d;
                    start_d = 1'b1;
                    wait_d  = 8'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: if (wait_q == 8'd0) begin
                done_d  = 1'b1;
                state_d = FIRST;
            end else begin
                wait_d = wait_q - 8'd1;
            end
            default: state_d = FIRST;
        endcase
        // handshake and busy are registered from the next state so they never depend on in_valid
        ready_d = state_d != WAIT;
        busy_d  = state_d == WAIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FIRST;
            cnt_q     <= 4'd0;
            wait_q    <= 8'd0;
            key_sh_q  <= '0;
            data_sh_q <= '0;
            key_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
            loaded_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            key_sh_q  <= key_sh_d;
            data_sh_q <= data_sh_d;
            key_q     <= key_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef AES_LOADER_KEY_REUSE_EN
            loaded_q  <= loaded_d;
`endif
        end
    end

    assign in_ready = ready_q;
    assign key_out  = key_q;
    assign data_out = data_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_aes_dec_loader.sv
// tb_aes_dec_loader: directed frames into two loaders (LATENCY 10 and 1) checked against a byte-queue model.
module tb_aes_dec_loader;
`ifdef AES_LOADER_KEY_REUSE_EN
    localparam bit HE = 1'b1;
`else
    localparam bit HE = 1'b0;
`endif
    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [1:0] rdy, st, bz, dn;
    logic [1:0][127:0] ko, dt;
    int total = 0, bad = 0, cyc = 0;
    int s_cyc [2];
    int bz1_cnt = 0;
    int hdr_at = -1;
    logic [127:0] cv;

    always #5 clk = ~clk;

    aes_dec_loader #(.LATENCY(10)) dut0 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .key_out(ko[0]), .data_out(dt[0]), .start(st[0]), .busy(bz[0]), .done(dn[0]));
    aes_dec_loader #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .key_out(ko[1]), .data_out(dt[1]), .start(st[1]), .busy(bz[1]), .done(dn[1]));

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, a, e);
        end
    endtask

    // inputs as seen by the DUTs at each rising edge
    logic s_rst = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_rst   <= rst_n;
        s_valid <= in_valid;
        s_data  <= in_data;
    end

    // model: a frame is an optional header, then 16-byte fields gathered in a queue; the wait is counted in cycles since start
    typedef enum int {P_HDR, P_KEY, P_DATA, P_WAIT} phase_t;
    phase_t ph [2];
    logic [7:0] fq [2][$];
    int lat [2] = '{10, 1};
    int since [2];
    bit loaded [2];
    logic [127:0] m_key [2], m_dat [2];
    logic m_rdy [2], m_st [2], m_bz [2], m_dn [2];
    logic [127:0] w;

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                if (!s_rst) begin
                    ph[i] = HE ? P_HDR : P_KEY;
                    fq[i].delete();
                    m_key[i] = '0; m_dat[i] = '0;
                    m_rdy[i] = 1'b0; m_st[i] = 1'b0; m_bz[i] = 1'b0; m_dn[i] = 1'b0;
                    loaded[i] = 1'b0;
                end else begin
                    m_st[i] = 1'b0;
                    m_dn[i] = 1'b0;
                    if (ph[i] == P_WAIT) begin
                        since[i]++;
                        if (since[i] == lat[i]) begin
                            m_dn[i] = 1'b1;
                            ph[i] = HE ? P_HDR : P_KEY;
                        end
                    end else if (s_valid && m_rdy[i]) begin
                        if (ph[i] == P_HDR) begin
                            ph[i] = (s_data[0] || !loaded[i]) ? P_KEY : P_DATA;
                        end else begin
                            fq[i].push_back(s_data);
                            if (fq[i].size() == 16) begin
                                w = '0;
                                foreach (fq[i][k]) w = {w[119:0], fq[i][k]};
                                fq[i].delete();
                                if (ph[i] == P_KEY) begin
                                    m_key[i] = w; loaded[i] = 1'b1; ph[i] = P_DATA;
                                end else begin
                                    m_dat[i] = w; m_st[i] = 1'b1; since[i] = 0; ph[i] = P_WAIT;
                                end
                            end
                        end
                    end
                    m_rdy[i] = ph[i] != P_WAIT;
                    m_bz[i]  = ph[i] == P_WAIT;
                end
                chk($sformatf("u%0d_in_ready", i), 128'(rdy[i]), 128'(m_rdy[i]));
                chk($sformatf("u%0d_start", i), 128'(st[i]), 128'(m_st[i]));
                chk($sformatf("u%0d_busy", i), 128'(bz[i]), 128'(m_bz[i]));
                chk($sformatf("u%0d_done", i), 128'(dn[i]), 128'(m_dn[i]));
                chk($sformatf("u%0d_key_out", i), ko[i], m_key[i]);
                chk($sformatf("u%0d_data_out", i), dt[i], m_dat[i]);
                if (st[i]) s_cyc[i] = cyc;
            end
            if (bz[1]) bz1_cnt++;
        end
    end

    task automatic send(input logic [7:0] b, input int idle, output int at);
        in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 200; n++) begin
            if (rdy[0]) begin
                @(negedge clk);
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL send_timeout cyc=%0d got=no_accept want=accept", cyc);
        at = -1;
    endtask

    task automatic frame(input bit send_hdr, input logic [7:0] hdr, input bit with_key, input int skip,
                         input int idle, input logic [7:0] km, output int first);
        int a;
        if (send_hdr) send(hdr, idle, hdr_at);
        first = -1;
        for (int n = skip; n < 32; n++) begin
            if (n < 16 && !with_key) continue;
            send(n < 16 ? (8'(n) ^ km) : cv[127 - 8 * (n - 16) -: 8], idle, a);
            if (first < 0) first = a;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        for (int n = 0; n < 300; n++) begin
            if (dn[0]) begin
                at = cyc;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL done_timeout cyc=%0d got=no_done want=done", cyc);
        at = -1;
    endtask

    initial begin
        int f, d, a;
        cv = C;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(rdy[0]), 128'(0));
        chk("reset_key_out", ko[0], 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 128'(rdy[0]), 128'(1));

        // back-to-back frame; header 00 right after reset must still load the key
        frame(HE, 8'h00, 1'b1, 0, 0, 8'h00, f);
        wait_done(d);
        chk("f1_model_key", m_key[0], K);
        chk("f1_key", ko[0], K);
        chk("f1_data", dt[0], C);
        chk("f1_start_after_first_byte", 128'(s_cyc[0] - f), 128'(31));
        chk("f1_done_latency", 128'(d - s_cyc[0]), 128'(10));
        chk("f1_lat1_start", 128'(s_cyc[1] - f), 128'(31));
        chk("f1_lat1_busy_cycles", 128'(bz1_cnt), 128'(1));

        // in_valid alternating: one idle cycle before every byte
        frame(HE, 8'h01, 1'b1, 0, 1, 8'h00, f);
        wait_done(d);
        chk("f2_key", ko[0], K);
        chk("f2_data", dt[0], C);
        chk("f2_start_after_first_byte", 128'(s_cyc[0] - f), 128'(62));
        chk("f2_done_latency", 128'(d - s_cyc[0]), 128'(10));

        // the next frame's first byte is offered throughout WAIT and must land on the done cycle
        frame(HE, 8'h01, 1'b1, 0, 0, 8'h00, f);
        send(8'h01 & {7'd0, HE}, 0, a);
        chk("busy_offer_accept_cycle", 128'(a - s_cyc[0]), 128'(11));
        frame(1'b0, 8'h00, 1'b1, HE ? 0 : 1, 0, 8'h00, f);
        wait_done(d);
        chk("f4_key", ko[0], K);
        chk("f4_data", dt[0], C);

        // reset part-way through a key, then a clean frame
        for (int n = 0; n < 7; n++) send(8'ha5 ^ 8'(n), 0, a);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midkey_reset_key", ko[0], 128'(0));
        chk("midkey_reset_ready", 128'(rdy[0]), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        frame(HE, 8'h00, 1'b1, 0, 0, 8'h00, f);
        wait_done(d);
        chk("f5_key", ko[0], K);
        chk("f5_data", dt[0], C);

        if (HE) begin
            // header 00 with a key held: data only, 17-cycle frame front end
            frame(1'b1, 8'h00, 1'b0, 0, 0, 8'h00, f);
            wait_done(d);
            chk("reuse_key_kept", ko[0], K);
            chk("reuse_data", dt[0], C);
            chk("reuse_start_after_hdr", 128'(s_cyc[0] - hdr_at), 128'(16));
            frame(1'b1, 8'h01, 1'b1, 0, 0, 8'hff, f);
            wait_done(d);
            chk("reload_new_key", ko[0], ~K);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
